// File: rtl/sub_cla32_seq.sv
// Sequential A - B - Bin subtractor: one NW-bit carry-lookahead slice per clock,
// with the inter-slice carry held in a register and a start/busy/done handshake.
module sub_cla32_seq #(
  parameter int DW = 32,
  parameter int NW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [DW-1:0] i_A,
  input  logic [DW-1:0] i_B,
  input  logic          i_Bin,
  output logic [DW-1:0] o_D,
  output logic          o_Bout,
  output logic          o_V,
  output logic          o_busy,
  output logic          o_done
);

  localparam int NS = DW / NW;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] a_q, a_d, bn_q, bn_d, work_q, work_d, d_q, d_d;
  logic          c_q, c_d, bout_q, bout_d, v_q, v_d;

  logic [NW-1:0] sa, sb, sg, sp, sSum;
  logic [NW:0]   sc;
  logic          term;

  // Subtraction is A + ~B + ~Bin; each carry is built as a flat sum of
  // generate terms gated by the propagates above them (lookahead, not ripple).
  always_comb begin
    sa    = a_q[cnt_q*NW +: NW];
    sb    = bn_q[cnt_q*NW +: NW];
    sg    = sa & sb;
    sp    = sa ^ sb;
    sc    = '0;
    term  = 1'b0;
    sc[0] = c_q;
    for (int i = 0; i < NW; i++) begin
      for (int j = 0; j <= i; j++) begin
        term = sg[j];
        for (int k = j + 1; k <= i; k++) term = term & sp[k];
        sc[i+1] = sc[i+1] | term;
      end
      term = c_q;
      for (int k = 0; k <= i; k++) term = term & sp[k];
      sc[i+1] = sc[i+1] | term;
    end
    sSum = sp ^ sc[NW-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    bn_d    = bn_q;
    c_d     = c_q;
    work_d  = work_q;
    d_d     = d_q;
    bout_d  = bout_q;
    v_d     = v_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          a_d     = i_A;
          bn_d    = ~i_B;
          c_d     = ~i_Bin;
          cnt_d   = '0;
          work_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d[cnt_q*NW +: NW] = sSum;
        c_d   = sc[NW];
        cnt_d = cnt_q + 1'b1;
        // Last slice: publish the complete result in one step.
        if (cnt_q == CW'(NS - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
          d_d     = work_d;
          bout_d  = ~sc[NW];
          v_d     = (a_q[DW-1] ^ ~bn_q[DW-1]) & (work_d[DW-1] ^ a_q[DW-1]);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      bn_q    <= '0;
      c_q     <= 1'b0;
      work_q  <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      bn_q    <= bn_d;
      c_q     <= c_d;
      work_q  <= work_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      v_q     <= v_d;
    end
  end

  assign o_D    = d_q;
  assign o_Bout = bout_q;
  assign o_V    = v_q;
  assign o_busy = (state_q != IDLE);
  assign o_done = (state_q == DONE);

endmodule
